controle_ula: RTL
=================

# controle_ula

Multi-cycle sequencer that sits in front of the combinational 16-bit ALU (5-bit operation code). It accepts one command at a time over a valid/ready handshake and drives the ALU operation and operand inputs. It can apply the same operation repeatedly, feeding each result back as operand A. It registers the final result with Z/N/C/O status flags, which the ALU does not produce itself, and holds them until the consumer accepts them.

## Interface
- `bits_palavra`, 16: datapath width.
- `bits_controle`, 5: ALU operation code width.
- `bits_rep`, 4: repeat-count width.

- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command can be accepted. Equals (state == OCIOSO) && !rst.
- `cmd_op` in bits_controle: ALU operation code.
- `cmd_a`, `cmd_b` in bits_palavra: initial operands A and B (signed).
- `cmd_rep` in bits_rep: number of extra iterations. The operation executes cmd_rep+1 times.
- `ula_controle` out bits_controle: ALU operation code output.
- `ula_a`, `ula_b` out bits_palavra: ALU operand outputs.
- `ula_resultado` in bits_palavra: ALU combinational result.
- `res_valid` out 1: result and flags valid.
- `res_ready` in 1: consumer accepts the result.
- `resultado` out bits_palavra: registered final result.
- `flag_z`, `flag_n`, `flag_c`, `flag_o` out 1: zero, sign, carry/borrow, signed overflow.

## Operation
- Three states: OCIOSO, EXECUTA, RESPOSTA.
- Reset: state goes to OCIOSO; `resultado`, all flags, `res_valid`, the iteration counter and the internal registers (op, acc, B) go to 0.
- **OCIOSO**
  - `cmd_ready`=1.
  - When cmd_valid && cmd_ready at an edge: latch op, acc←cmd_a, B←cmd_b, cnt←cmd_rep; go to EXECUTA.
- **EXECUTA**
  - Drive ula_controle=op, ula_a=acc, ula_b=B.
  - Each edge: acc←ula_resultado.
  - If cnt≠0: cnt←cnt−1 and stay in EXECUTA.
  - If cnt==0: resultado←ula_resultado, update flags, go to RESPOSTA.
- **RESPOSTA**
  - `res_valid`=1; resultado and flags held stable.
  - When res_ready=1 at an edge: go to OCIOSO.
- Outside EXECUTA: ula_controle=5'b10000 (constant zero), ula_a=0, ula_b=0.
- Flags are computed only on the final iteration, from that iteration's operands a=acc, b=B and r=ula_resultado:
  - **Z** = (r == 0). **N** = r[msb].
  - **Add family** (00000 k=0, 00001 k=1, 00011 with b:=1, k=0):
    - C = bit 16 of {0,a}+{0,b}+k.
    - O = (a[msb]==b[msb]) && (r[msb]≠a[msb]).
  - **Subtract family** (00101 k=0, 00100 k=1, 00110 with b:=1, k=0):
    - C = borrow, i.e. ({0,a} < {0,b}+k).
    - O = (a[msb]≠b[msb]) && (r[msb]≠a[msb]).
  - **01000** (logical shift left): C=a[msb], O=0.
  - **01001** (arithmetic shift right): C=a[0], O=0.
  - **All other codes**, including undefined ones: C=0, O=0. Undefined codes yield r=0, so Z=1.
- Flags keep their previous values in all states except on the final EXECUTA edge.
- Commands are never accepted outside OCIOSO. cmd_* inputs are ignored while cmd_ready=0.

## Timing
- Accept edge at cycle 0.
- EXECUTA occupies cycles 1..cmd_rep+1.
- res_valid rises in cycle cmd_rep+2. Latency is cmd_rep+2 cycles from the accept edge.
- Return to OCIOSO takes one cycle after the res_ready edge. Next accept is at earliest the cycle after that.
- Back-to-back throughput: cmd_rep+3 cycles per command when res_ready is held at 1.
- res_ready asserted outside RESPOSTA has no effect.
- Reset asserted mid-operation (any state):
  - Immediate return to OCIOSO; all outputs cleared.
  - The command in flight is discarded; no res_valid is produced for it.
- cmd_rep=0: a single EXECUTA cycle.
- cmd_rep=max (15): 16 iterations. The counter does not wrap, because the decrement stops at 0.

## Test plan
- op=00000, a=0x7FFF, b=0x0001, rep=0 → res_valid at cycle 2; resultado=0x8000, N=1, O=1, C=0, Z=0.
- op=00000, a=0xFFFF, b=0x0001 → resultado=0x0000, Z=1, C=1, O=0, N=0.
- op=00101, a=0x0000, b=0x0001 → resultado=0xFFFF, C=1 (borrow), N=1, O=0.
- op=01000, a=0x1234, rep=3 → ula_a sequence 0x1234, 0x2468, 0x48D0, 0x91A0; resultado=0x2340 at cycle 5; C=1, Z=0.
- op=01001, a=0x8003, rep=1 → resultado=0xE000, C=1, N=1.
  - Then hold res_ready=0 for 3 cycles while cmd_valid=1 → outputs stable, cmd_ready=0, no new command accepted.
- Accept op=00000, rep=5; assert rst in cycle 3 → all outputs 0 at once, cmd_ready=1 after release, no res_valid for the discarded command.

Source files
------------

// File: rtl/controle_ula.sv
// controle_ula: multi-cycle sequencer in front of the combinational 16-bit ALU.
// Repeats one operation with the result fed back as A, then holds the result and Z/N/C/O until accepted.
module controle_ula #(
  parameter int bits_palavra  = 16,
  parameter int bits_controle = 5,
  parameter int bits_rep      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [bits_controle-1:0] cmd_op,
  input  logic [bits_palavra-1:0]  cmd_a,
  input  logic [bits_palavra-1:0]  cmd_b,
  input  logic [bits_rep-1:0]      cmd_rep,
  output logic [bits_controle-1:0] ula_controle,
  output logic [bits_palavra-1:0]  ula_a,
  output logic [bits_palavra-1:0]  ula_b,
  input  logic [bits_palavra-1:0]  ula_resultado,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [bits_palavra-1:0]  resultado,
  output logic                     flag_z,
  output logic                     flag_n,
  output logic                     flag_c,
  output logic                     flag_o
);

  localparam int MSB = bits_palavra - 1;
  localparam logic [bits_controle-1:0] OP_ADD  = bits_controle'(5'b00000);
  localparam logic [bits_controle-1:0] OP_ADDC = bits_controle'(5'b00001);
  localparam logic [bits_controle-1:0] OP_INC  = bits_controle'(5'b00011);
  localparam logic [bits_controle-1:0] OP_SUBB = bits_controle'(5'b00100);
  localparam logic [bits_controle-1:0] OP_SUB  = bits_controle'(5'b00101);
  localparam logic [bits_controle-1:0] OP_DEC  = bits_controle'(5'b00110);
  localparam logic [bits_controle-1:0] OP_SHL  = bits_controle'(5'b01000);
  localparam logic [bits_controle-1:0] OP_ASR  = bits_controle'(5'b01001);
  localparam logic [bits_controle-1:0] OP_ZERO = bits_controle'(5'b10000);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    EXECUTA  = 2'd1,
    RESPOSTA = 2'd2
  } estado_t;

  estado_t                  r_estado, w_prox;
  logic [bits_controle-1:0] r_op;
  logic [bits_palavra-1:0]  r_acc, r_b, r_resultado;
  logic [bits_rep-1:0]      r_cnt;
  logic                     r_flag_z, r_flag_n, r_flag_c, r_flag_o;
  logic [bits_palavra-1:0]  w_b_eff;
  logic                     w_k, w_carry, w_borrow, w_c, w_o, w_aceita;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_estado <= OCIOSO;
    else     r_estado <= w_prox;
  end

  always_comb begin
    w_prox       = r_estado;
    ula_controle = OP_ZERO;
    ula_a        = '0;
    ula_b        = '0;
    case (r_estado)
      OCIOSO:   if (w_aceita) w_prox = EXECUTA;
      EXECUTA: begin
        ula_controle = r_op;
        ula_a        = r_acc;
        ula_b        = r_b;
        if (r_cnt == '0) w_prox = RESPOSTA;
      end
      RESPOSTA: if (res_ready) w_prox = OCIOSO;
      default:  w_prox = OCIOSO;
    endcase
  end

  assign cmd_ready = (r_estado == OCIOSO) && !rst;
  assign w_aceita  = cmd_valid && cmd_ready;
  assign res_valid = (r_estado == RESPOSTA);
  assign resultado = r_resultado;
  assign flag_z    = r_flag_z;
  assign flag_n    = r_flag_n;
  assign flag_c    = r_flag_c;
  assign flag_o    = r_flag_o;

  // Increment/decrement ignore the B operand; their flags behave as if B were 1.
  always_comb begin
    w_b_eff = r_b;
    w_k     = 1'b0;
    case (r_op)
      OP_ADDC, OP_SUBB: w_k = 1'b1;
      OP_INC, OP_DEC:   w_b_eff = bits_palavra'(1);
      default: ;
    endcase
  end

  assign w_carry  = ({1'b0, r_acc} + {1'b0, w_b_eff} + {{bits_palavra{1'b0}}, w_k})
                    > {1'b0, {bits_palavra{1'b1}}};
  assign w_borrow = {1'b0, r_acc} < ({1'b0, w_b_eff} + {{bits_palavra{1'b0}}, w_k});

  always_comb begin
    w_c = 1'b0;
    w_o = 1'b0;
    case (r_op)
      OP_ADD, OP_ADDC, OP_INC: begin
        w_c = w_carry;
        w_o = (r_acc[MSB] == w_b_eff[MSB]) && (ula_resultado[MSB] != r_acc[MSB]);
      end
      OP_SUB, OP_SUBB, OP_DEC: begin
        w_c = w_borrow;
        w_o = (r_acc[MSB] != w_b_eff[MSB]) && (ula_resultado[MSB] != r_acc[MSB]);
      end
      OP_SHL:  w_c = r_acc[MSB];
      OP_ASR:  w_c = r_acc[0];
      default: ;
    endcase
  end

  // Result and flags only move on the last iteration; the counter stops at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op        <= '0;
      r_acc       <= '0;
      r_b         <= '0;
      r_cnt       <= '0;
      r_resultado <= '0;
      r_flag_z    <= 1'b0;
      r_flag_n    <= 1'b0;
      r_flag_c    <= 1'b0;
      r_flag_o    <= 1'b0;
    end else begin
      case (r_estado)
        OCIOSO: if (w_aceita) begin
          r_op  <= cmd_op;
          r_acc <= cmd_a;
          r_b   <= cmd_b;
          r_cnt <= cmd_rep;
        end
        EXECUTA: begin
          r_acc <= ula_resultado;
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - bits_rep'(1);
          end else begin
            r_resultado <= ula_resultado;
            r_flag_z    <= (ula_resultado == '0);
            r_flag_n    <= ula_resultado[MSB];
            r_flag_c    <= w_c;
            r_flag_o    <= w_o;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
